ldr_load_unit: RTL and testbench
================================

// Module: ldr_load_unit
// PURPOSE
//  Executes LDR instructions for the register file. Takes the decoded 32-bit
//  instruction word and base operand (source1), computes the address, does a
//  req/ack data-memory read, then drives LDRdata/LDRsel for a single-cycle
//  register write. Sits downstream of decode/register read and feeds the
//  register file's write port.
// PARAMETERS
//  ADDR_W   16        data-memory address width
//  LDR_OP   5'b10100  opcode value in code[31:27] identifying an LDR
//  TIMEOUT  15        max cycles in REQ waiting for mem_ack before abort (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  code       in   32      instruction: [31:27] op, [22:19] dest, [14:11] src1, [10:0] imm
//  start      in   1       instruction valid; sampled only in IDLE
//  base       in   32      source1 value from register file
//  busy       out  1       load in progress; upstream holds code stable while high
//  mem_req    out  1       memory read request, level
//  mem_addr   out  ADDR_W  read address, stable while mem_req high
//  mem_rdata  in   32      read data, valid with mem_ack
//  mem_ack    in   1       read complete, one-cycle pulse
//  LDRdata    out  32      write-back data to register file
//  LDRsel     out  1       register-file write enable, one-cycle pulse
//  ldr_dest   out  4       latched code[22:19], for checking/forwarding
//  done       out  1       load completed (pulse, same cycle as LDRsel)
//  err        out  1       load aborted on timeout (pulse)
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, every output 0, counter 0.
//  - FSM IDLE -> REQ -> WB -> IDLE; REQ -> IDLE on timeout.
//  - IDLE: start=1 and code[31:27]==LDR_OP -> latch dest and
//    addr = (base + sign_ext(code[10:0]))[ADDR_W-1:0] (wraps modulo 2^ADDR_W);
//    next cycle busy=1, mem_req=1, go REQ. start with other opcode: ignored.
//  - REQ: mem_req=1, mem_addr held. On mem_ack: capture mem_rdata into LDRdata,
//    go WB. Cycles in REQ counted from 1; if count reaches TIMEOUT with no ack:
//    mem_req=0, busy=0, err=1 for one cycle, no write, back to IDLE.
//  - Ack on the TIMEOUT cycle itself wins: normal write-back, no err.
//  - WB: LDRsel=1, done=1, busy=1 for exactly one cycle; LDRdata held until
//    next capture (not cleared). Then IDLE, busy=0.
//  - Latency: start at edge N -> mem_req high after N; ack at N+1 -> LDRsel high
//    after N+2. Min start-to-start spacing 3 cycles.
//  - start while busy: ignored (not queued). mem_ack in IDLE/WB: ignored.
//  - Reset mid-operation: immediate return to IDLE, mem_req/LDRsel drop
//    asynchronously, no partial write-back.
// TESTING
//  1. Reset then base=0x100, imm=0x004, dest=5, LDR start; ack after 2 cycles
//     with 0xDEADBEEF -> mem_addr=0x0104, one LDRsel pulse, LDRdata=0xDEADBEEF,
//     ldr_dest=5, r5 reads 0xDEADBEEF.
//  2. base=0x0010, imm=0x7FC (-4) -> mem_addr=0x000C; base=0xFFFF, imm=1 ->
//     mem_addr=0x0000 (wrap).
//  3. No ack: mem_req high exactly 15 cycles, then err pulse, LDRsel never high,
//     busy low; ack on cycle 15 -> normal write-back, err stays 0.
//  4. start with op!=LDR_OP -> busy/mem_req stay 0; start pulsed during REQ ->
//     only one memory request issued.
//  5. Assert rst while in REQ and again in WB -> all outputs 0 next sample,
//     register file contents unchanged; new LDR afterwards completes normally.
//  6. Back-to-back LDRs to dest 1 and 2 with immediate acks -> two LDRsel pulses
//     3 cycles apart, each with correct LDRdata/ldr_dest.

Source files
------------

// File: rtl/ldr_load_unit.sv
// LDR execution unit: computes base+sign-extended offset, performs one req/ack
// data-memory read and emits a single-cycle register-file write-back.
module ldr_load_unit #(
  parameter int unsigned ADDR_W  = 16,
  parameter logic [4:0]  LDR_OP  = 5'b10100,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       code,
  input  logic              start,
  input  logic [31:0]       base,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       LDRdata,
  output logic              LDRsel,
  output logic [3:0]        ldr_dest,
  output logic              done,
  output logic              err
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WB
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_mem_req;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_ldr_data;
  logic               r_ldr_sel;
  logic [3:0]         r_ldr_dest;
  logic               r_done;
  logic               r_err;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_busy_nxt;
  logic               w_mem_req_nxt;
  logic [ADDR_W-1:0]  w_mem_addr_nxt;
  logic [31:0]        w_ldr_data_nxt;
  logic               w_ldr_sel_nxt;
  logic [3:0]         w_ldr_dest_nxt;
  logic               w_done_nxt;
  logic               w_err_nxt;

  logic               w_is_ldr;
  logic [31:0]        w_imm_sext;
  logic [31:0]        w_addr_sum;
  logic               w_unused;

  assign w_is_ldr   = (code[31:27] == LDR_OP);
  assign w_imm_sext = {{21{code[10]}}, code[10:0]};
  // Full 32-bit sum; only the low ADDR_W bits leave the block, giving the wrap.
  assign w_addr_sum = base + w_imm_sext;
  assign w_unused   = ^{code[26:23], code[18:11], w_addr_sum[31:ADDR_W]};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_busy_nxt     = 1'b0;
    w_mem_req_nxt  = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_ldr_data_nxt = r_ldr_data;
    w_ldr_sel_nxt  = 1'b0;
    w_ldr_dest_nxt = r_ldr_dest;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start && w_is_ldr) begin
          w_state_nxt    = S_REQ;
          w_cnt_nxt      = CNT_W'(1);
          w_busy_nxt     = 1'b1;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = w_addr_sum[ADDR_W-1:0];
          w_ldr_dest_nxt = code[22:19];
        end
      end
      S_REQ: begin
        // An ack arriving on the final allowed cycle still completes the load.
        if (mem_ack) begin
          w_state_nxt    = S_WB;
          w_cnt_nxt      = '0;
          w_busy_nxt     = 1'b1;
          w_ldr_data_nxt = mem_rdata;
        end else if (r_cnt >= CNT_MAX) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt     = r_cnt + CNT_W'(1);
          w_busy_nxt    = 1'b1;
          w_mem_req_nxt = 1'b1;
        end
      end
      S_WB: begin
        w_state_nxt   = S_IDLE;
        w_busy_nxt    = 1'b1;
        w_ldr_sel_nxt = 1'b1;
        w_done_nxt    = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_ldr_data <= '0;
      r_ldr_sel  <= 1'b0;
      r_ldr_dest <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_ldr_data <= w_ldr_data_nxt;
      r_ldr_sel  <= w_ldr_sel_nxt;
      r_ldr_dest <= w_ldr_dest_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign busy     = r_busy;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign LDRdata  = r_ldr_data;
  assign LDRsel   = r_ldr_sel;
  assign ldr_dest = r_ldr_dest;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_ldr_load_unit.sv
// Directed bench for ldr_load_unit: address generation, write-back timing,
// timeout abort, ignored starts/acks, mid-operation reset and back-to-back loads.
module tb_ldr_load_unit;

  localparam logic [4:0] OP_LDR = 5'b10100;

  logic        clk;
  logic        rst;
  logic [31:0] code;
  logic        start;
  logic [31:0] base;
  logic        busy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] LDRdata;
  logic        LDRsel;
  logic [3:0]  ldr_dest;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // Downstream register file and activity monitors.
  logic [31:0] rf [16] = '{default: 32'h0};
  int          sel_cnt   = 0;
  int          req_rises = 0;
  int          cyc       = 0;
  logic        req_q     = 1'b0;

  ldr_load_unit #(.ADDR_W(16), .LDR_OP(5'b10100), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .code(code), .start(start), .base(base),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .LDRdata(LDRdata),
    .LDRsel(LDRsel), .ldr_dest(ldr_dest), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (LDRsel) begin
      rf[ldr_dest] <= LDRdata;
      sel_cnt++;
    end
    if (mem_req && !req_q) req_rises++;
    req_q <= mem_req;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] dest,
                       input logic [31:0] b, input logic [10:0] imm);
    code  = {op, 4'h0, dest, 4'h0, 4'h0, imm};
    base  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Ack immediately, then step through write-back until back in idle.
  task automatic finish_ack(input logic [31:0] data);
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; code = '0; base = '0; mem_rdata = '0;
    repeat (3) tick();
    n_cmp++; if ({busy, mem_req, LDRsel, done, err} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want %b", {busy, mem_req, LDRsel, done, err}, 5'b0); end
    n_cmp++; if (mem_addr !== 16'h0) begin n_bad++; $display("FAIL reset_addr: got %h want %h", mem_addr, 16'h0); end
    n_cmp++; if (LDRdata !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want %h", LDRdata, 32'h0); end
    n_cmp++; if (ldr_dest !== 4'h0) begin n_bad++; $display("FAIL reset_dest: got %h want %h", ldr_dest, 4'h0); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load;
    int s0;
    s0 = sel_cnt;
    issue(OP_LDR, 4'd5, 32'h0000_0100, 11'h004);
    n_cmp++; if ({busy, mem_req} !== 2'b11) begin n_bad++; $display("FAIL t1_req: got %b want %b", {busy, mem_req}, 2'b11); end
    n_cmp++; if (mem_addr !== 16'h0104) begin n_bad++; $display("FAIL t1_addr: got %h want %h", mem_addr, 16'h0104); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    n_cmp++; if ({LDRsel, mem_req, busy} !== 3'b001) begin n_bad++; $display("FAIL t1_capture_ctrl: got %b want %b", {LDRsel, mem_req, busy}, 3'b001); end
    tick();
    n_cmp++; if ({LDRsel, done, busy} !== 3'b111) begin n_bad++; $display("FAIL t1_wb: got %b want %b", {LDRsel, done, busy}, 3'b111); end
    n_cmp++; if (LDRdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL t1_data: got %h want %h", LDRdata, 32'hDEAD_BEEF); end
    n_cmp++; if (ldr_dest !== 4'd5) begin n_bad++; $display("FAIL t1_dest: got %h want %h", ldr_dest, 4'd5); end
    tick();
    n_cmp++; if ({LDRsel, done, busy} !== 3'b000) begin n_bad++; $display("FAIL t1_idle: got %b want %b", {LDRsel, done, busy}, 3'b000); end
    n_cmp++; if (sel_cnt - s0 !== 1) begin n_bad++; $display("FAIL t1_sel_pulses: got %0d want %0d", sel_cnt - s0, 1); end
    n_cmp++; if (rf[5] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL t1_r5: got %h want %h", rf[5], 32'hDEAD_BEEF); end
    n_cmp++; if (LDRdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL t1_data_held: got %h want %h", LDRdata, 32'hDEAD_BEEF); end
  endtask

  task automatic test_addr_gen;
    issue(OP_LDR, 4'd6, 32'h0000_0010, 11'h7FC);
    n_cmp++; if (mem_addr !== 16'h000C) begin n_bad++; $display("FAIL t2_neg_imm: got %h want %h", mem_addr, 16'h000C); end
    tick();
    n_cmp++; if (mem_addr !== 16'h000C) begin n_bad++; $display("FAIL t2_addr_stable: got %h want %h", mem_addr, 16'h000C); end
    finish_ack(32'h0000_0606);
    issue(OP_LDR, 4'd6, 32'h0000_FFFF, 11'h001);
    n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL t2_wrap: got %h want %h", mem_addr, 16'h0000); end
    finish_ack(32'h0000_0607);
  endtask

  task automatic test_timeout;
    int req_n, err_n, err_idx, s0;
    logic busy_at_err;
    s0 = sel_cnt; req_n = 0; err_n = 0; err_idx = -1; busy_at_err = 1'b1;
    issue(OP_LDR, 4'd10, 32'h0000_0500, 11'h000);
    for (int i = 0; i < 20; i++) begin
      if (mem_req) req_n++;
      if (err) begin err_n++; err_idx = i; busy_at_err = busy; end
      tick();
    end
    n_cmp++; if (req_n !== 15) begin n_bad++; $display("FAIL t3_req_cycles: got %0d want %0d", req_n, 15); end
    n_cmp++; if (err_n !== 1) begin n_bad++; $display("FAIL t3_err_pulses: got %0d want %0d", err_n, 1); end
    n_cmp++; if (err_idx !== 15) begin n_bad++; $display("FAIL t3_err_when: got %0d want %0d", err_idx, 15); end
    n_cmp++; if (busy_at_err !== 1'b0) begin n_bad++; $display("FAIL t3_busy_at_err: got %b want %b", busy_at_err, 1'b0); end
    n_cmp++; if (sel_cnt - s0 !== 0) begin n_bad++; $display("FAIL t3_no_write: got %0d want %0d", sel_cnt - s0, 0); end
    n_cmp++; if (rf[10] !== 32'h0) begin n_bad++; $display("FAIL t3_r10: got %h want %h", rf[10], 32'h0); end

    issue(OP_LDR, 4'd11, 32'h0000_0600, 11'h000);
    repeat (14) tick();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL t3_req_c14: got %b want %b", mem_req, 1'b1); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0015;
    tick();
    mem_ack = 1'b0;
    n_cmp++; if ({err, mem_req, busy} !== 3'b001) begin n_bad++; $display("FAIL t3_late_ack: got %b want %b", {err, mem_req, busy}, 3'b001); end
    tick();
    n_cmp++; if ({LDRsel, err} !== 2'b10) begin n_bad++; $display("FAIL t3_late_wb: got %b want %b", {LDRsel, err}, 2'b10); end
    n_cmp++; if (LDRdata !== 32'hCAFE_0015) begin n_bad++; $display("FAIL t3_late_data: got %h want %h", LDRdata, 32'hCAFE_0015); end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t3_late_err: got %b want %b", err, 1'b0); end
  endtask

  task automatic test_ignored_inputs;
    int s0, r0;
    s0 = sel_cnt;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    tick();
    n_cmp++; if (LDRdata !== 32'hCAFE_0015) begin n_bad++; $display("FAIL t4_idle_ack_data: got %h want %h", LDRdata, 32'hCAFE_0015); end
    n_cmp++; if (sel_cnt - s0 !== 0) begin n_bad++; $display("FAIL t4_idle_ack_sel: got %0d want %0d", sel_cnt - s0, 0); end

    issue(5'b00001, 4'd4, 32'h0000_0100, 11'h000);
    n_cmp++; if ({busy, mem_req} !== 2'b00) begin n_bad++; $display("FAIL t4_bad_op: got %b want %b", {busy, mem_req}, 2'b00); end
    tick();
    n_cmp++; if ({busy, mem_req} !== 2'b00) begin n_bad++; $display("FAIL t4_bad_op_later: got %b want %b", {busy, mem_req}, 2'b00); end

    r0 = req_rises;
    issue(OP_LDR, 4'd3, 32'h0000_0200, 11'h000);
    tick();
    issue(OP_LDR, 4'd4, 32'h0000_0400, 11'h010);
    n_cmp++; if (mem_addr !== 16'h0200) begin n_bad++; $display("FAIL t4_busy_addr: got %h want %h", mem_addr, 16'h0200); end
    n_cmp++; if (ldr_dest !== 4'd3) begin n_bad++; $display("FAIL t4_busy_dest: got %h want %h", ldr_dest, 4'd3); end
    finish_ack(32'h0000_0333);
    repeat (3) tick();
    n_cmp++; if (req_rises - r0 !== 1) begin n_bad++; $display("FAIL t4_one_request: got %0d want %0d", req_rises - r0, 1); end
    n_cmp++; if ({busy, mem_req} !== 2'b00) begin n_bad++; $display("FAIL t4_settled: got %b want %b", {busy, mem_req}, 2'b00); end
    n_cmp++; if (rf[3] !== 32'h0000_0333) begin n_bad++; $display("FAIL t4_r3: got %h want %h", rf[3], 32'h0000_0333); end
  endtask

  task automatic test_mid_reset;
    int s0;
    s0 = sel_cnt;
    issue(OP_LDR, 4'd7, 32'h0000_0300, 11'h000);
    rst = 1'b1;
    #1;
    n_cmp++; if ({busy, mem_req, LDRsel, done, err} !== 5'b0) begin n_bad++; $display("FAIL t5_req_rst_ctrl: got %b want %b", {busy, mem_req, LDRsel, done, err}, 5'b0); end
    n_cmp++; if ({mem_addr, ldr_dest} !== 20'h0) begin n_bad++; $display("FAIL t5_req_rst_regs: got %h want %h", {mem_addr, ldr_dest}, 20'h0); end
    tick();
    rst = 1'b0;
    tick();

    issue(OP_LDR, 4'd8, 32'h0000_0310, 11'h000);
    mem_ack = 1'b1; mem_rdata = 32'h8888_8888;
    tick();
    mem_ack = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if ({busy, mem_req, LDRsel, done, err} !== 5'b0) begin n_bad++; $display("FAIL t5_wb_rst_ctrl: got %b want %b", {busy, mem_req, LDRsel, done, err}, 5'b0); end
    n_cmp++; if (LDRdata !== 32'h0) begin n_bad++; $display("FAIL t5_wb_rst_data: got %h want %h", LDRdata, 32'h0); end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++; if (sel_cnt - s0 !== 0) begin n_bad++; $display("FAIL t5_no_write: got %0d want %0d", sel_cnt - s0, 0); end
    n_cmp++; if ({rf[7], rf[8]} !== 64'h0) begin n_bad++; $display("FAIL t5_rf_kept: got %h want %h", {rf[7], rf[8]}, 64'h0); end

    issue(OP_LDR, 4'd9, 32'h0000_0320, 11'h010);
    n_cmp++; if (mem_addr !== 16'h0330) begin n_bad++; $display("FAIL t5_after_addr: got %h want %h", mem_addr, 16'h0330); end
    finish_ack(32'h9999_0009);
    n_cmp++; if (rf[9] !== 32'h9999_0009) begin n_bad++; $display("FAIL t5_after_r9: got %h want %h", rf[9], 32'h9999_0009); end
  endtask

  task automatic test_back_to_back;
    int p1, p2;
    p1 = 0; p2 = 0;
    issue(OP_LDR, 4'd1, 32'h0000_0700, 11'h001);
    mem_ack = 1'b1; mem_rdata = 32'h1111_AAAA;
    tick();
    mem_ack = 1'b0;
    tick();
    p1 = cyc;
    n_cmp++; if ({LDRsel, ldr_dest} !== {1'b1, 4'd1}) begin n_bad++; $display("FAIL t6_first_sel_dest: got %h want %h", {LDRsel, ldr_dest}, {1'b1, 4'd1}); end
    n_cmp++; if (LDRdata !== 32'h1111_AAAA) begin n_bad++; $display("FAIL t6_first_data: got %h want %h", LDRdata, 32'h1111_AAAA); end
    issue(OP_LDR, 4'd2, 32'h0000_0800, 11'h002);
    n_cmp++; if ({mem_req, LDRsel} !== 2'b10) begin n_bad++; $display("FAIL t6_second_req: got %b want %b", {mem_req, LDRsel}, 2'b10); end
    n_cmp++; if (mem_addr !== 16'h0802) begin n_bad++; $display("FAIL t6_second_addr: got %h want %h", mem_addr, 16'h0802); end
    mem_ack = 1'b1; mem_rdata = 32'h2222_BBBB;
    tick();
    mem_ack = 1'b0;
    tick();
    p2 = cyc;
    n_cmp++; if ({LDRsel, ldr_dest} !== {1'b1, 4'd2}) begin n_bad++; $display("FAIL t6_second_sel_dest: got %h want %h", {LDRsel, ldr_dest}, {1'b1, 4'd2}); end
    n_cmp++; if (LDRdata !== 32'h2222_BBBB) begin n_bad++; $display("FAIL t6_second_data: got %h want %h", LDRdata, 32'h2222_BBBB); end
    n_cmp++; if (p2 - p1 !== 3) begin n_bad++; $display("FAIL t6_spacing: got %0d want %0d", p2 - p1, 3); end
    tick();
    n_cmp++; if ({rf[1], rf[2]} !== {32'h1111_AAAA, 32'h2222_BBBB}) begin n_bad++; $display("FAIL t6_rf: got %h want %h", {rf[1], rf[2]}, {32'h1111_AAAA, 32'h2222_BBBB}); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_addr_gen();
    test_timeout();
    test_ignored_inputs();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
